track_supervisor: RTL and testbench

Parametrised run-time supervisor for the chase pipeline. It sits between the tracker/control blocks and the motor pins. It owns the INITIALIZE→SELECTED→CONFIRMED→MOVE/PAUSE/LOST sequence and holds per-frame target measurements, substituting defaults when the target is missing. It also slew-limits each motor channel's signed speed command once per frame and gates motor enables to MOVE only, so that a lost target or a pause stops the robot safely.

---
 rtl/track_pkg.sv | 22 ++
 rtl/speed_ramp.sv | 50 +++++
 rtl/track_supervisor.sv | 147 ++++++++++++++
 tb/tb_track_supervisor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared types and default parameters for the chase-pipeline supervisor.
package track_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_SELECTED  = 3'd1,
        ST_CONFIRMED = 3'd2,
        ST_MOVE      = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_LOST      = 3'd5
    } state_t;

    localparam int COORD_W_DEF     = 9;
    localparam int RAD_W_DEF       = 7;
    localparam int SPEED_W_DEF     = 9;
    localparam int NUM_MOTORS_DEF  = 2;
    localparam int LOST_FRAMES_DEF = 8;
    localparam int RAMP_STEP_DEF   = 4;
    localparam int X_DEFAULT_DEF   = 160;
    localparam int MIN_RAD_DEF     = 10;

endpackage

// File: rtl/speed_ramp.sv
// One motor channel: signed speed register that moves towards the command
// by at most RAMP_STEP per step, or snaps to zero when cleared.
module speed_ramp #(
    parameter int SPEED_W   = 9,
    parameter int RAMP_STEP = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clear_in,
    input  logic               step_in,
    input  logic [SPEED_W-1:0] cmd_in,
    output logic [SPEED_W-1:0] speed_out
);

    localparam logic signed [SPEED_W:0] STEP_POS = (SPEED_W+1)'(RAMP_STEP);
    localparam logic signed [SPEED_W:0] STEP_NEG = -STEP_POS;

    logic [SPEED_W-1:0]      speed_q, speed_d;
    logic signed [SPEED_W:0] diff, delta, sum;

    // One extra bit keeps cmd - speed exact for any pair of SPEED_W values.
    always_comb begin
        diff = $signed({cmd_in[SPEED_W-1], cmd_in}) - $signed({speed_q[SPEED_W-1], speed_q});
        if (diff > STEP_POS) begin
            delta = STEP_POS;
        end else if (diff < STEP_NEG) begin
            delta = STEP_NEG;
        end else begin
            delta = diff;
        end
        sum     = $signed({speed_q[SPEED_W-1], speed_q}) + delta;
        speed_d = speed_q;
        if (clear_in) begin
            speed_d = '0;
        end else if (step_in) begin
            speed_d = sum[SPEED_W-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            speed_q <= '0;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed_out = speed_q;

endmodule

// File: rtl/track_supervisor.sv
// Run-time supervisor: selection/confirmation FSM, per-frame measurement hold
// with missing-target defaults, and per-channel slew-limited motor speeds.
module track_supervisor
    import track_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int RAD_W       = RAD_W_DEF,
    parameter int SPEED_W     = SPEED_W_DEF,
    parameter int NUM_MOTORS  = NUM_MOTORS_DEF,
    parameter int LOST_FRAMES = LOST_FRAMES_DEF,
    parameter int RAMP_STEP   = RAMP_STEP_DEF,
    parameter int X_DEFAULT   = X_DEFAULT_DEF,
    parameter int MIN_RAD     = MIN_RAD_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          frame_done_in,
    input  logic                          activate_in,
    input  logic                          confirm_in,
    input  logic                          pause_in,
    input  logic                          target_valid_in,
    input  logic [COORD_W-1:0]            x_in,
    input  logic [COORD_W-1:0]            y_in,
    input  logic [RAD_W-1:0]              rad_in,
    input  logic [RAD_W-1:0]              goal_rad_in,
    input  logic [NUM_MOTORS*SPEED_W-1:0] speed_cmd_in,
    output logic [NUM_MOTORS*SPEED_W-1:0] speed_out,
    output logic [NUM_MOTORS-1:0]         motor_en_out,
    output logic [COORD_W-1:0]            x_out,
    output logic [COORD_W-1:0]            y_out,
    output logic [RAD_W-1:0]              rad_out,
    output logic [2:0]                    state_out,
    output logic                          lost_out
);

    localparam int                 CNT_W     = $clog2(LOST_FRAMES + 1);
    localparam logic [CNT_W-1:0]   LOST_MAX  = CNT_W'(LOST_FRAMES);
    localparam logic [COORD_W-1:0] X_DEF_V   = COORD_W'(X_DEFAULT);
    localparam logic [RAD_W-1:0]   MIN_RAD_V = RAD_W'(MIN_RAD);

    state_t                  state_q, state_d;
    logic                    confirm_q;
    logic [COORD_W-1:0]      x_q, x_d, y_q, y_d;
    logic [RAD_W-1:0]        rad_q, rad_d;
    logic [CNT_W-1:0]        lost_cnt_q, lost_cnt_d;
    logic [NUM_MOTORS-1:0]   motor_en_q, motor_en_d;
    logic                    lost_q, lost_d;
    logic                    confirm_edge;
    logic                    ramp_clear;

    always_comb begin
        confirm_edge = confirm_in & ~confirm_q;
        x_d          = x_q;
        y_d          = y_q;
        rad_d        = rad_q;
        lost_cnt_d   = lost_cnt_q;
        if (frame_done_in) begin
            if (target_valid_in) begin
                x_d        = x_in;
                y_d        = y_in;
                rad_d      = (rad_in < MIN_RAD_V) ? goal_rad_in : rad_in;
                lost_cnt_d = '0;
            end else begin
                x_d = X_DEF_V;
                if (lost_cnt_q != LOST_MAX) begin
                    lost_cnt_d = lost_cnt_q + 1'b1;
                end
            end
        end

        state_d = state_q;
        if (!activate_in) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:      if (confirm_edge) state_d = ST_SELECTED;
                ST_SELECTED:  if (confirm_edge) state_d = ST_CONFIRMED;
                ST_CONFIRMED: if (frame_done_in && target_valid_in) state_d = ST_MOVE;
                ST_MOVE: begin
                    if (pause_in) begin
                        state_d = ST_PAUSE;
                    end else if (frame_done_in && !target_valid_in && lost_cnt_d == LOST_MAX) begin
                        state_d = ST_LOST;
                    end
                end
                ST_PAUSE:     if (!pause_in && frame_done_in) state_d = ST_MOVE;
                ST_LOST: begin
                    if (pause_in) begin
                        state_d = ST_PAUSE;
                    end else if (frame_done_in && target_valid_in) begin
                        state_d = ST_MOVE;
                    end
                end
                default:      state_d = ST_INIT;
            endcase
        end

        motor_en_d = (state_d == ST_MOVE) ? {NUM_MOTORS{1'b1}} : '0;
        lost_d     = (state_d == ST_LOST);
        // Speeds only live while MOVE persists; any entry into MOVE starts from zero.
        ramp_clear = !(state_q == ST_MOVE && state_d == ST_MOVE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_INIT;
            confirm_q  <= 1'b0;
            x_q        <= X_DEF_V;
            y_q        <= '0;
            rad_q      <= '0;
            lost_cnt_q <= '0;
            motor_en_q <= '0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            confirm_q  <= confirm_in;
            x_q        <= x_d;
            y_q        <= y_d;
            rad_q      <= rad_d;
            lost_cnt_q <= lost_cnt_d;
            motor_en_q <= motor_en_d;
            lost_q     <= lost_d;
        end
    end

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ramp
        speed_ramp #(
            .SPEED_W   (SPEED_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_ramp (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .clear_in  (ramp_clear),
            .step_in   (frame_done_in),
            .cmd_in    (speed_cmd_in[i*SPEED_W +: SPEED_W]),
            .speed_out (speed_out[i*SPEED_W +: SPEED_W])
        );
    end

    assign state_out    = state_q;
    assign motor_en_out = motor_en_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign rad_out      = rad_q;
    assign lost_out     = lost_q;

endmodule

// File: tb/tb_track_supervisor.sv
// Directed bench for track_supervisor: a behavioural model checked every
// cycle plus literal expectations taken from worked examples.
module tb_track_supervisor;

    logic        clk;
    logic        rst_n;
    logic        frame_done;
    logic        activate;
    logic        confirm;
    logic        pause;
    logic        valid;
    logic [8:0]  x_i, y_i;
    logic [6:0]  rad_i, goal_rad;
    logic [17:0] speed_cmd;
    logic [17:0] speed_o;
    logic [1:0]  motor_en;
    logic [8:0]  x_o, y_o;
    logic [6:0]  rad_o;
    logic [2:0]  state_o;
    logic        lost_o;

    int n_checks = 0;
    int n_pass   = 0;

    track_supervisor dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .frame_done_in   (frame_done),
        .activate_in     (activate),
        .confirm_in      (confirm),
        .pause_in        (pause),
        .target_valid_in (valid),
        .x_in            (x_i),
        .y_in            (y_i),
        .rad_in          (rad_i),
        .goal_rad_in     (goal_rad),
        .speed_cmd_in    (speed_cmd),
        .speed_out       (speed_o),
        .motor_en_out    (motor_en),
        .x_out           (x_o),
        .y_out           (y_o),
        .rad_out         (rad_o),
        .state_out       (state_o),
        .lost_out        (lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sp(input int ch);
        logic [8:0] v;
        v = speed_o[ch*9 +: 9];
        return int'($signed(v));
    endfunction

    // Behavioural model: states as plain integers 0..5, speeds as ints.
    int m_state, m_x, m_y, m_rad, m_lost, m_conf;
    int m_sp[2];
    int nxt, new_lost, dlt, cmdv;
    bit cedge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_x = 160; m_y = 0; m_rad = 0; m_lost = 0; m_conf = 0;
            m_sp[0] = 0; m_sp[1] = 0;
        end else begin
            cedge    = confirm && (m_conf == 0);
            new_lost = m_lost;
            if (frame_done) new_lost = valid ? 0 : ((m_lost + 1 > 8) ? 8 : m_lost + 1);
            nxt = m_state;
            if (!activate) nxt = 0;
            else if (m_state == 0 && cedge) nxt = 1;
            else if (m_state == 1 && cedge) nxt = 2;
            else if (m_state == 2 && frame_done && valid) nxt = 3;
            else if (m_state == 3 && pause) nxt = 4;
            else if (m_state == 3 && frame_done && !valid && new_lost == 8) nxt = 5;
            else if (m_state == 4 && !pause && frame_done) nxt = 3;
            else if (m_state == 5 && pause) nxt = 4;
            else if (m_state == 5 && frame_done && valid) nxt = 3;
            for (int c = 0; c < 2; c++) begin
                if (m_state != 3 || nxt != 3) begin
                    m_sp[c] = 0;
                end else if (frame_done) begin
                    cmdv = int'($signed(speed_cmd[c*9 +: 9]));
                    dlt  = cmdv - m_sp[c];
                    if (dlt > 4) dlt = 4;
                    if (dlt < -4) dlt = -4;
                    m_sp[c] = m_sp[c] + dlt;
                end
            end
            if (frame_done) begin
                if (valid) begin
                    m_x = x_i; m_y = y_i;
                    m_rad = (rad_i < 10) ? int'(goal_rad) : int'(rad_i);
                end else begin
                    m_x = 160;
                end
            end
            m_lost  = new_lost;
            m_conf  = confirm;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        chk("cmp_state", state_o, m_state);
        chk("cmp_speed0", sp(0), m_sp[0]);
        chk("cmp_speed1", sp(1), m_sp[1]);
        chk("cmp_en", motor_en, (m_state == 3) ? 3 : 0);
        chk("cmp_x", x_o, m_x);
        chk("cmp_y", y_o, m_y);
        chk("cmp_rad", rad_o, m_rad);
        chk("cmp_lost", lost_o, (m_state == 5) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input bit v, input int x, input int y, input int r);
        frame_done = 1'b1;
        valid      = v;
        x_i        = 9'(x);
        y_i        = 9'(y);
        rad_i      = 7'(r);
        cyc(1);
        frame_done = 1'b0;
    endtask

    task automatic confirm_pulse();
        confirm = 1'b1;
        cyc(1);
        confirm = 1'b0;
        cyc(1);
    endtask

    int exp0[6] = '{4, 8, 12, 16, 20, 20};
    int exp1[6] = '{-4, -8, -9, -9, -9, -9};

    initial begin
        rst_n = 1'b0; frame_done = 0; activate = 0; confirm = 0; pause = 0; valid = 0;
        x_i = '0; y_i = '0; rad_i = '0; goal_rad = 7'd25;
        speed_cmd = {9'(-9), 9'(20)};
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk("reset_state", state_o, 0);
        chk("reset_x", x_o, 160);
        chk("reset_speed", speed_o, 0);

        activate = 1'b1;
        cyc(1);
        confirm_pulse();
        chk("sel_state", state_o, 1);
        confirm = 1'b1;
        frame(1, 77, 40, 20);
        chk("confirm_with_frame_state", state_o, 2);
        chk("confirm_with_frame_x", x_o, 77);
        cyc(1);
        confirm = 1'b0;
        cyc(1);
        confirm_pulse();
        chk("edge_ignored_confirmed", state_o, 2);

        frame(1, 100, 60, 20);
        chk("enter_move_state", state_o, 3);
        chk("enter_move_en", motor_en, 3);
        chk("enter_move_speed", speed_o, 0);
        for (int i = 0; i < 6; i++) begin
            frame(1, 100, 60, 20);
            chk("ramp_ch0", sp(0), exp0[i]);
            chk("ramp_ch1", sp(1), exp1[i]);
        end

        for (int i = 1; i <= 8; i++) begin
            frame(0, 0, 0, 0);
            if (i == 7) chk("lost_after7_state", state_o, 3);
        end
        chk("lost_state", state_o, 5);
        chk("lost_flag", lost_o, 1);
        chk("lost_speed", speed_o, 0);
        chk("lost_x", x_o, 160);
        frame(1, 200, 70, 20);
        chk("relock_state", state_o, 3);
        chk("relock_x", x_o, 200);
        chk("relock_speed", speed_o, 0);
        frame(1, 200, 70, 20);
        chk("relock_ramp", sp(0), 4);

        frame(1, 200, 70, 20);
        pause = 1'b1;
        frame(1, 200, 70, 20);
        chk("pause_state", state_o, 4);
        chk("pause_speed", speed_o, 0);
        chk("pause_en", motor_en, 0);
        cyc(1);
        pause = 1'b0;
        cyc(2);
        chk("pause_hold", state_o, 4);
        frame(1, 200, 70, 20);
        chk("unpause_state", state_o, 3);

        frame(1, 150, 80, 6);
        chk("rad_small", rad_o, 25);
        frame(1, 150, 80, 30);
        chk("rad_big", rad_o, 30);
        frame(1, 150, 80, 30);
        frame(1, 150, 80, 30);
        chk("speed16", sp(0), 16);
        activate = 1'b0;
        cyc(1);
        chk("deact_state", state_o, 0);
        chk("deact_speed", speed_o, 0);

        activate = 1'b1;
        cyc(1);
        confirm_pulse();
        confirm_pulse();
        frame(1, 120, 90, 40);
        frame(1, 120, 90, 40);
        frame(1, 120, 90, 40);
        chk("pre_reset_speed", sp(0), 8);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", state_o, 0);
        chk("async_speed", speed_o, 0);
        chk("async_en", motor_en, 0);
        chk("async_x", x_o, 160);
        chk("async_y", y_o, 0);
        chk("async_rad", rad_o, 0);
        chk("async_lost", lost_o, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
